// File: rtl/branch_pkg.sv
`default_nettype none
// ============================================================================
// branch_pkg : shared types and the taken-decision rule for branch resolution
// Rev 1.0
// ============================================================================
package branch_pkg;

  localparam int BR_OP_W = 2;

  typedef enum logic [BR_OP_W-1:0] {
    BR_NOP = 2'b00,
    BR_BEQ = 2'b01,
    BR_BNE = 2'b10,
    BR_JMP = 2'b11
  } br_op_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_FLUSH    = 2'd2
  } br_state_t;

  function automatic logic br_taken(input br_op_t op, input logic eq);
    logic t;
    t = 1'b0;
    case (op)
      BR_BEQ:  t = eq;
      BR_BNE:  t = ~eq;
      BR_JMP:  t = 1'b1;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage
`default_nettype wire

// File: rtl/branch_stats.sv
`default_nettype none
// ============================================================================
// branch_stats : saturating pair of branch/taken event counters
// Rev 1.0
// ============================================================================
module branch_stats #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc_br,
  input  logic                 inc_taken,
  output logic [CNT_WIDTH-1:0] br_count,
  output logic [CNT_WIDTH-1:0] taken_count
);

  logic [CNT_WIDTH-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_WIDTH-1:0] tk_cnt_q, tk_cnt_d;

  always_comb begin
    br_cnt_d = br_cnt_q;
    tk_cnt_d = tk_cnt_q;
    if (inc_br && (br_cnt_q != '1)) br_cnt_d = br_cnt_q + 1'b1;
    if (inc_taken && (tk_cnt_q != '1)) tk_cnt_d = tk_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      br_cnt_q <= '0;
      tk_cnt_q <= '0;
    end else begin
      br_cnt_q <= br_cnt_d;
      tk_cnt_q <= tk_cnt_d;
    end
  end

  assign br_count    = br_cnt_q;
  assign taken_count = tk_cnt_q;

endmodule
`default_nettype wire

// File: rtl/branch_resolve.sv
`default_nettype none
// ============================================================================
// branch_resolve : resolves branches from the EQUAL compare, redirects fetch
// and holds FLUSH. Define BRANCH_STATS_EN to add BR_COUNT/TAKEN_COUNT.
// Rev 1.0
// ============================================================================
module branch_resolve
  import branch_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  BR_VALID,
  output logic                  BR_READY,
  input  logic [BR_OP_W-1:0]    BR_OP,
  input  logic [WIDTH-1:0]      EQUAL,
  input  logic [ADDR_WIDTH-1:0] BR_TARGET,
  output logic                  PC_SEL,
  output logic [ADDR_WIDTH-1:0] PC_TARGET,
  output logic                  FLUSH
`ifdef BRANCH_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]  BR_COUNT,
  output logic [CNT_WIDTH-1:0]  TAKEN_COUNT
`endif
);

  // Counter covers the cycles after the redirect cycle: FLUSH_CYCLES-2 .. 0
  localparam int FCNT_W = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES - 1) : 1;
  localparam logic [FCNT_W-1:0] FCNT_LOAD =
    FCNT_W'((FLUSH_CYCLES > 2) ? (FLUSH_CYCLES - 2) : 0);

  br_state_t             state_q, state_d;
  logic [FCNT_W-1:0]     cnt_q, cnt_d;
  logic                  pc_sel_q, pc_sel_d;
  logic                  flush_q, flush_d;
  logic [ADDR_WIDTH-1:0] pc_target_q, pc_target_d;

  br_op_t op;
  logic   accept;
  logic   taken;

  assign op       = br_op_t'(BR_OP);
  assign BR_READY = (state_q == ST_IDLE) & ~RST;
  assign accept   = BR_VALID & BR_READY;
  assign taken    = br_taken(op, |EQUAL);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_target_d = pc_target_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && taken) begin
          pc_target_d = BR_TARGET;
          state_d     = ST_REDIRECT;
        end
      end
      ST_REDIRECT: begin
        if (FLUSH_CYCLES <= 1) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d   = FCNT_LOAD;
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    // Outputs are registered images of the next state
    pc_sel_d = (state_d == ST_REDIRECT);
    flush_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      pc_sel_q    <= 1'b0;
      flush_q     <= 1'b0;
      pc_target_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pc_sel_q    <= pc_sel_d;
      flush_q     <= flush_d;
      pc_target_q <= pc_target_d;
    end
  end

  assign PC_SEL    = pc_sel_q;
  assign FLUSH     = flush_q;
  assign PC_TARGET = pc_target_q;

`ifdef BRANCH_STATS_EN
  branch_stats #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_stats (
    .clk         (CLK),
    .rst         (RST),
    .inc_br      (accept & (op != BR_NOP)),
    .inc_taken   (accept & taken),
    .br_count    (BR_COUNT),
    .taken_count (TAKEN_COUNT)
  );
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve.sv
`default_nettype none
// ============================================================================
// tb_branch_resolve : directed vector table plus randomized run vs. a model
// Rev 1.0
// ============================================================================
module tb_branch_resolve;

  localparam int FC    = 2;
  localparam int CW    = 16;
  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_BEQ = 2'b01;
  localparam logic [1:0] OP_BNE = 2'b10;
  localparam logic [1:0] OP_JMP = 2'b11;

  logic        clk = 1'b0;
  logic        RST = 1'b1;
  logic        BR_VALID = 1'b0;
  logic        BR_READY;
  logic [1:0]  BR_OP = 2'b00;
  logic [31:0] EQUAL = 32'd0;
  logic [31:0] BR_TARGET = 32'd0;
  logic        PC_SEL;
  logic [31:0] PC_TARGET;
  logic        FLUSH;
`ifdef BRANCH_STATS_EN
  logic [CW-1:0] BR_COUNT;
  logic [CW-1:0] TAKEN_COUNT;
`endif

  branch_resolve #(
    .WIDTH        (32),
    .ADDR_WIDTH   (32),
    .FLUSH_CYCLES (FC),
    .CNT_WIDTH    (CW)
  ) dut (
    .CLK       (clk),
    .RST       (RST),
    .BR_VALID  (BR_VALID),
    .BR_READY  (BR_READY),
    .BR_OP     (BR_OP),
    .EQUAL     (EQUAL),
    .BR_TARGET (BR_TARGET),
    .PC_SEL    (PC_SEL),
    .PC_TARGET (PC_TARGET),
    .FLUSH     (FLUSH)
`ifdef BRANCH_STATS_EN
    ,
    .BR_COUNT    (BR_COUNT),
    .TAKEN_COUNT (TAKEN_COUNT)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: remaining occupancy cycles after a taken accept
  int          m_rem = 0;
  logic [31:0] m_tgt = 32'd0;
  longint      m_br  = 0;
  longint      m_tk  = 0;
  logic        rdy_pre;
  logic        m_rdy_pre;
  localparam longint CMAX = (64'd1 << CW) - 1;

  typedef struct {
    logic        rst;
    logic        v;
    logic [1:0]  op;
    logic [31:0] eq;
    logic [31:0] tgt;
    logic        rdy;
    logic        sel;
    logic        fl;
    logic [31:0] ptgt;
  } vec_t;

  vec_t tbl[22];

  function automatic bit m_taken(input logic [1:0] op, input logic [31:0] eq);
    case (op)
      OP_BEQ:  return eq != 32'd0;
      OP_BNE:  return eq == 32'd0;
      OP_JMP:  return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Drive one cycle (call at negedge); samples BR_READY before the edge
  task automatic apply(input logic r, input logic v, input logic [1:0] op,
                       input logic [31:0] eq, input logic [31:0] tgt);
    RST = r; BR_VALID = v; BR_OP = op; EQUAL = eq; BR_TARGET = tgt;
    #1;
    rdy_pre   = BR_READY;
    m_rdy_pre = (m_rem == 0) && !r;
    @(posedge clk);
    if (r) begin
      m_rem = 0; m_tgt = 32'd0; m_br = 0; m_tk = 0;
    end else if (m_rem > 0) begin
      m_rem--;
    end else if (v) begin
      if (op != OP_NOP && m_br < CMAX) m_br++;
      if (m_taken(op, eq)) begin
        m_rem = FC;
        m_tgt = tgt;
        if (m_tk < CMAX) m_tk++;
      end
    end
    #1;
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b1, OP_JMP, 32'd0, 32'h55,  1'b0, 1'b0, 1'b0, 32'h0};
    tbl[1]  = '{1'b1, 1'b1, OP_JMP, 32'd0, 32'h55,  1'b0, 1'b0, 1'b0, 32'h0};
    tbl[2]  = '{1'b1, 1'b1, OP_JMP, 32'd0, 32'h55,  1'b0, 1'b0, 1'b0, 32'h0};
    tbl[3]  = '{1'b0, 1'b1, OP_BEQ, 32'd1, 32'h100, 1'b1, 1'b1, 1'b1, 32'h100};
    tbl[4]  = '{1'b0, 1'b0, OP_NOP, 32'd0, 32'h0,   1'b0, 1'b0, 1'b1, 32'h100};
    tbl[5]  = '{1'b0, 1'b0, OP_NOP, 32'd0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h100};
    tbl[6]  = '{1'b0, 1'b1, OP_BEQ, 32'd0, 32'h300, 1'b1, 1'b0, 1'b0, 32'h100};
    tbl[7]  = '{1'b0, 1'b1, OP_BNE, 32'd1, 32'h304, 1'b1, 1'b0, 1'b0, 32'h100};
    tbl[8]  = '{1'b0, 1'b1, OP_BNE, 32'd0, 32'h200, 1'b1, 1'b1, 1'b1, 32'h200};
    tbl[9]  = '{1'b0, 1'b1, OP_BEQ, 32'd5, 32'h400, 1'b0, 1'b0, 1'b1, 32'h200};
    tbl[10] = '{1'b0, 1'b1, OP_BEQ, 32'd5, 32'h400, 1'b0, 1'b0, 1'b0, 32'h200};
    tbl[11] = '{1'b0, 1'b1, OP_BEQ, 32'd5, 32'h400, 1'b1, 1'b1, 1'b1, 32'h400};
    tbl[12] = '{1'b0, 1'b0, OP_NOP, 32'd0, 32'h0,   1'b0, 1'b0, 1'b1, 32'h400};
    tbl[13] = '{1'b0, 1'b0, OP_NOP, 32'd0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h400};
    tbl[14] = '{1'b0, 1'b1, OP_JMP, 32'd0, 32'h500, 1'b1, 1'b1, 1'b1, 32'h500};
    tbl[15] = '{1'b1, 1'b0, OP_NOP, 32'd0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0};
    tbl[16] = '{1'b0, 1'b1, OP_NOP, 32'd1, 32'h600, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[17] = '{1'b0, 1'b1, OP_JMP, 32'd0, 32'h700, 1'b1, 1'b1, 1'b1, 32'h700};
    tbl[18] = '{1'b0, 1'b0, OP_NOP, 32'd0, 32'h0,   1'b0, 1'b0, 1'b1, 32'h700};
    tbl[19] = '{1'b0, 1'b0, OP_NOP, 32'd0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h700};
    tbl[20] = '{1'b1, 1'b1, OP_JMP, 32'd0, 32'h800, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[21] = '{1'b0, 1'b0, OP_NOP, 32'd0, 32'h0,   1'b1, 1'b0, 1'b0, 32'h0};

    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      apply(tbl[i].rst, tbl[i].v, tbl[i].op, tbl[i].eq, tbl[i].tgt);
      chk($sformatf("tbl%0d ready", i), 64'(rdy_pre), 64'(tbl[i].rdy));
      chk($sformatf("tbl%0d pc_sel", i), 64'(PC_SEL), 64'(tbl[i].sel));
      chk($sformatf("tbl%0d flush", i), 64'(FLUSH), 64'(tbl[i].fl));
      chk($sformatf("tbl%0d pc_target", i), 64'(PC_TARGET), 64'(tbl[i].ptgt));
    end

    for (int n = 0; n < 400; n++) begin
      logic        r, v;
      logic [1:0]  op;
      logic [31:0] eq, tgt;
      r   = ($urandom_range(0, 39) == 0);
      v   = ($urandom_range(0, 3) != 0);
      op  = 2'($urandom_range(0, 3));
      eq  = ($urandom_range(0, 1) == 0) ? 32'd0 : (32'd1 << $urandom_range(0, 31));
      tgt = $urandom;
      @(negedge clk);
      apply(r, v, op, eq, tgt);
      chk("rnd ready", 64'(rdy_pre), 64'(m_rdy_pre));
      chk("rnd pc_sel", 64'(PC_SEL), 64'(m_rem == FC));
      chk("rnd flush", 64'(FLUSH), 64'(m_rem > 0));
      chk("rnd pc_target", 64'(PC_TARGET), 64'(m_tgt));
`ifdef BRANCH_STATS_EN
      chk("rnd br_count", 64'(BR_COUNT), 64'(m_br));
      chk("rnd taken_count", 64'(TAKEN_COUNT), 64'(m_tk));
`endif
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
